// File: rtl/flash_adc_encoder_seq.sv
// -----------------------------------------------------------------------------
// flash_adc_encoder_seq
//
// Clocked thermometer-to-binary encoder for the flash ADC comparator bank.
// Synchronises the raw comparator outputs, repairs single-bit thermometer
// bubbles with a 3-input majority vote, registers a binary code on each
// sample strobe and produces a truncated block average over 2^AVG_LOG2
// samples.
//
// Optional feature macro: PEAK_HOLD_EN (adds peak_clr, peak_max, peak_min).
//
// Parameters:
//   N_BITS      output code width; comparator count M = 2^N_BITS - 1
//   SYNC_STAGES synchroniser depth on each comparator input (use >= 2)
//   AVG_LOG2    log2 of samples per average block (0 = pass-through)
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset (released synchronously inside)
//   comp_in     raw comparator outputs, bit i high when Vin > (i+1) LSB
//   sample_en   single-cycle sample strobe
//   code_out    corrected binary code of the last sample
//   code_valid  one-cycle pulse when code_out updates
//   bubble_err  correction changed the raw pattern (valid with code_valid)
//   overrange   all comparators high after correction (valid with code_valid)
//   avg_out     truncated mean of the last completed block
//   avg_valid   one-cycle pulse when avg_out updates
//   peak_clr    (PEAK_HOLD_EN) synchronous clear of the peak trackers
//   peak_max    (PEAK_HOLD_EN) largest code_out since reset/clear
//   peak_min    (PEAK_HOLD_EN) smallest code_out since reset/clear
// -----------------------------------------------------------------------------
module flash_adc_encoder_seq #(
    parameter int N_BITS      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AVG_LOG2    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [(2**N_BITS)-2:0]    comp_in,
    input  logic                      sample_en,
    output logic [N_BITS-1:0]         code_out,
    output logic                      code_valid,
    output logic                      bubble_err,
    output logic                      overrange,
    output logic [N_BITS-1:0]         avg_out,
    output logic                      avg_valid
`ifdef PEAK_HOLD_EN
    ,
    input  logic                      peak_clr,
    output logic [N_BITS-1:0]         peak_max,
    output logic [N_BITS-1:0]         peak_min
`endif
);

    localparam int M     = (2**N_BITS) - 1;
    localparam int ACC_W = N_BITS + AVG_LOG2;

    // 2-of-3 vote used for bubble repair
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic           rst_meta_r;
    logic           rst_sync_r;
    logic [M-1:0]   sync_r [SYNC_STAGES];
    logic [M-1:0]   samp_s;
    logic [M+1:0]   ext_s;
    logic [M-1:0]   corr_s;
    logic [N_BITS-1:0] code_s;

    // Reset bridge: asserts immediately with rst, deasserts two clk edges later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= 1'b1;
        end else begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= rst_meta_r;
        end
    end

    // Comparator synchroniser chain, shifts every cycle
    always_ff @(posedge clk or posedge rst_sync_r) begin
        if (rst_sync_r) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= comp_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign samp_s = sync_r[SYNC_STAGES-1];

    // Virtual boundaries: below bit 0 reads as 1, above bit M-1 reads as 0
    assign ext_s = {1'b0, samp_s, 1'b1};

    for (genvar g = 0; g < M; g++) begin : g_corr
        assign corr_s[g] = maj3(ext_s[g], ext_s[g+1], ext_s[g+2]);
    end

    // Priority encoder: highest set bit wins, so residual non-thermometer
    // patterns still resolve to the top-most 1
    always_comb begin
        code_s = '0;
        for (int i = 0; i < M; i++) begin
            if (corr_s[i]) begin
                code_s = N_BITS'(i + 1);
            end else begin
                code_s = code_s;
            end
        end
    end

    // Sample register: captures code and flags on each strobe, holds otherwise
    always_ff @(posedge clk or posedge rst_sync_r) begin
        if (rst_sync_r) begin
            code_out   <= '0;
            code_valid <= 1'b0;
            bubble_err <= 1'b0;
            overrange  <= 1'b0;
        end else begin
            code_valid <= sample_en;
            if (sample_en) begin
                code_out   <= code_s;
                bubble_err <= (corr_s != samp_s);
                overrange  <= &corr_s;
            end
        end
    end

    if (AVG_LOG2 == 0) begin : g_avg_direct
        // Single-sample "average": follow code_out one cycle behind
        always_ff @(posedge clk or posedge rst_sync_r) begin
            if (rst_sync_r) begin
                avg_out   <= '0;
                avg_valid <= 1'b0;
            end else begin
                avg_valid <= code_valid;
                if (code_valid) begin
                    avg_out <= code_out;
                end
            end
        end
    end else begin : g_avg_block
        logic [ACC_W-1:0]    acc_r;
        logic [AVG_LOG2-1:0] cnt_r;
        logic [ACC_W-1:0]    sum_s;

        // ACC_W bits hold 2^AVG_LOG2 maximal codes, so the sum cannot wrap
        assign sum_s = acc_r + ACC_W'(code_out);

        // Block accumulator: emits the mean when the counter wraps
        always_ff @(posedge clk or posedge rst_sync_r) begin
            if (rst_sync_r) begin
                acc_r     <= '0;
                cnt_r     <= '0;
                avg_out   <= '0;
                avg_valid <= 1'b0;
            end else begin
                avg_valid <= 1'b0;
                if (code_valid) begin
                    cnt_r <= cnt_r + AVG_LOG2'(1);
                    if (cnt_r == {AVG_LOG2{1'b1}}) begin
                        avg_out   <= N_BITS'(sum_s >> AVG_LOG2);
                        acc_r     <= '0;
                        avg_valid <= 1'b1;
                    end else begin
                        acc_r <= sum_s;
                    end
                end
            end
        end
    end

`ifdef PEAK_HOLD_EN
    // Peak trackers: clear takes priority over a coincident sample
    always_ff @(posedge clk or posedge rst_sync_r) begin
        if (rst_sync_r) begin
            peak_max <= '0;
            peak_min <= '1;
        end else if (peak_clr) begin
            peak_max <= '0;
            peak_min <= '1;
        end else if (code_valid) begin
            if (code_out > peak_max) begin
                peak_max <= code_out;
            end
            if (code_out < peak_min) begin
                peak_min <= code_out;
            end
        end
    end
`endif

endmodule

// File: tb/tb_flash_adc_encoder_seq.sv
module tb_flash_adc_encoder_seq;

    logic       clk;
    logic       rst;
    logic [6:0] comp_in;
    logic       sample_en;
    logic [2:0] code_out;
    logic       code_valid;
    logic       bubble_err;
    logic       overrange;
    logic [2:0] avg_out;
    logic       avg_valid;
`ifdef PEAK_HOLD_EN
    logic       peak_clr;
    logic [2:0] peak_max;
    logic [2:0] peak_min;
`endif

    int n_checks = 0;
    int n_errors = 0;

    flash_adc_encoder_seq #(
        .N_BITS(3),
        .SYNC_STAGES(2),
        .AVG_LOG2(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .comp_in(comp_in),
        .sample_en(sample_en),
        .code_out(code_out),
        .code_valid(code_valid),
        .bubble_err(bubble_err),
        .overrange(overrange),
        .avg_out(avg_out),
        .avg_valid(avg_valid)
`ifdef PEAK_HOLD_EN
        ,
        .peak_clr(peak_clr),
        .peak_max(peak_max),
        .peak_min(peak_min)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] comp;
        int         code;
        int         bub;
        int         ovr;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] therm(input int n);
        logic [7:0] t;
        t = (8'd1 << n) - 8'd1;
        return t[6:0];
    endfunction

    task automatic check_zero(input string tag);
        check({tag, " code_out"},   code_out,   0);
        check({tag, " code_valid"}, code_valid, 0);
        check({tag, " bubble_err"}, bubble_err, 0);
        check({tag, " overrange"},  overrange,  0);
        check({tag, " avg_out"},    avg_out,    0);
        check({tag, " avg_valid"},  avg_valid,  0);
`ifdef PEAK_HOLD_EN
        check({tag, " peak_max"},   peak_max,   0);
        check({tag, " peak_min"},   peak_min,   7);
`endif
    endtask

    // Reset with sample_en held high to show it is ignored
    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst = 1'b1;
        sample_en = 1'b1;
        #1;
        check_zero({tag, " async"});
        repeat (2) @(posedge clk);
        #1;
        check_zero({tag, " held"});
        sample_en = 1'b0;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check({tag, " post code_valid"}, code_valid, 0);
    endtask

    // Leaves the caller in the cycle where code_valid should be high
    task automatic apply_sample(input logic [6:0] v);
        comp_in = v;
        sample_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    // Four back-to-back samples streamed through the synchroniser
    task automatic run_block(input int c0, input int c1, input int c2, input int c3,
                             input int exp_avg, input string tag);
        int codes[4];
        int n_avg, avg_at, last_cv, got, k;
        codes = '{c0, c1, c2, c3};
        n_avg = 0; avg_at = -1; last_cv = -1; got = -1; k = 0;
        for (int j = 0; j < 10; j++) begin
            if (j < 4) comp_in = therm(codes[j]);
            sample_en = (j >= 2 && j < 6);
            @(posedge clk);
            #1;
            if (code_valid) begin
                if (k < 4) check({tag, " code"}, code_out, codes[k]);
                k++;
                last_cv = j;
            end
            if (avg_valid) begin
                n_avg++;
                avg_at = j;
                got = avg_out;
            end
        end
        sample_en = 1'b0;
        check({tag, " code_valid count"}, k, 4);
        check({tag, " avg_valid count"}, n_avg, 1);
        check({tag, " avg_valid timing"}, avg_at, last_cv + 1);
        check({tag, " avg_out"}, got, exp_avg);
    endtask

    initial begin
        rst = 1'b0;
        comp_in = 7'b0000000;
        sample_en = 1'b0;
`ifdef PEAK_HOLD_EN
        peak_clr = 1'b0;
`endif

        vecs[0] = '{7'b0000111, 3, 0, 0};
        vecs[1] = '{7'b0001011, 3, 1, 0};
        vecs[2] = '{7'b0000000, 0, 0, 0};
        vecs[3] = '{7'b1111111, 7, 0, 1};
        vecs[4] = '{7'b0111111, 6, 0, 0};
        vecs[5] = '{7'b0000001, 1, 0, 0};
        vecs[6] = '{7'b0000100, 0, 1, 0};
        vecs[7] = '{7'b1011111, 6, 1, 0};
        vecs[8] = '{7'b1110000, 7, 0, 0};

        #2;
        do_reset("init");

        // Encoding table with hold check on the following idle cycle
        for (int i = 0; i < 9; i++) begin
            apply_sample(vecs[i].comp);
            check($sformatf("vec%0d code_valid", i), code_valid, 1);
            check($sformatf("vec%0d code_out", i),   code_out,   vecs[i].code);
            check($sformatf("vec%0d bubble_err", i), bubble_err, vecs[i].bub);
            check($sformatf("vec%0d overrange", i),  overrange,  vecs[i].ovr);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d hold code_valid", i), code_valid, 0);
            check($sformatf("vec%0d hold code_out", i),   code_out,   vecs[i].code);
            check($sformatf("vec%0d hold bubble_err", i), bubble_err, vecs[i].bub);
            check($sformatf("vec%0d hold overrange", i),  overrange,  vecs[i].ovr);
        end

        // Averaging on an aligned block boundary
        do_reset("pre_avg");
        run_block(2, 3, 3, 4, 3, "blk1");
        run_block(7, 7, 7, 6, 6, "blk2");

        // Reset mid-block discards the partial sum and counter
        apply_sample(therm(7));
        apply_sample(therm(7));
        check("midblk code_out", code_out, 7);
        do_reset("midblk");
        run_block(1, 1, 1, 1, 1, "blk3");

`ifdef PEAK_HOLD_EN
        do_reset("peak");
        apply_sample(therm(4));
        apply_sample(therm(1));
        apply_sample(therm(6));
        @(posedge clk);
        #1;
        check("peak_max", peak_max, 6);
        check("peak_min", peak_min, 1);
        apply_sample(therm(5));
        peak_clr = 1'b1;
        @(posedge clk);
        #1;
        peak_clr = 1'b0;
        check("peak clr max", peak_max, 0);
        check("peak clr min", peak_min, 7);
        @(posedge clk);
        #1;
        check("peak after clr max", peak_max, 0);
        check("peak after clr min", peak_min, 7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
